alu_ex_retire_stage: RTL
========================

// Module: alu_ex_retire_stage
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the 64-bit ALU. Registers the ALU
//  result, zero flag and writeback control. Resolves branches from the zero flag and
//  computes the branch target. A valid/ready handshake with a 2-entry skid buffer
//  lets MEM stall without creating a combinational ready path back into EX.
// PARAMETERS
//  XLEN  64  datapath width of result, pc, imm, target
//  REGW  5   destination register index width
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous reset, active-high
//  flush       in   1     synchronous kill of all held beats (pipeline redirect)
//  in_valid    in   1     EX beat valid
//  in_ready    out  1     stage can accept a beat
//  in_result   in   XLEN  ALU result
//  in_zero     in   1     ALU zero flag
//  in_rd       in   REGW  destination register
//  in_we       in   1     register write enable
//  in_branch   in   1     beat is a conditional branch (BEQ/BNE)
//  in_bne      in   1     1=BNE, 0=BEQ
//  in_pc       in   XLEN  branch instruction PC
//  in_imm      in   XLEN  sign-extended branch offset
//  out_valid   out  1     MEM beat valid
//  out_ready   in   1     MEM accepts beat
//  out_result  out  XLEN  registered result
//  out_rd      out  REGW  registered rd
//  out_we      out  1     registered write enable (0 when rd==0)
//  br_taken    out  1     branch taken, qualified by out_valid
//  br_target   out  XLEN  pc+imm of head beat
//  occupancy   out  2     beats held (0..2)
// BEHAVIOUR
//  - Reset: all outputs, both valid bits and all data registers = 0. in_ready = 1, but
//    inputs are ignored while rst is high.
//  - Storage: main reg (drives outputs) and skid reg. in_ready = ~skid_valid, registered
//    with no combinational path from out_ready.
//  - Accept when in_valid & in_ready. Latency: an accepted beat appears on outputs the
//    next cycle when main is empty or draining. Otherwise it goes to skid.
//  - Pop when out_valid & out_ready. On pop, skid moves to main if present, else main
//    takes the same-cycle accepted beat, else main goes empty.
//  - Simultaneous accept and pop with main full, skid empty: the new beat goes to main.
//    Occupancy stays at 1.
//  - Full: occupancy==2 forces in_ready=0. Ready rises the cycle after a pop.
//  - Order is strictly FIFO; no beat is ever dropped or duplicated outside flush.
//  - Output fields are stable while out_valid & ~out_ready.
//  - Captured out_we = in_we & (in_rd != 0).
//  - Captured br_taken = in_branch & (in_zero ^ in_bne). br_taken is 0 when out_valid=0.
//  - Captured br_target = (in_pc + in_imm) mod 2^XLEN, wrapping silently.
//  - flush: next edge clears both valid bits and sets occupancy to 0. Any beat offered in
//    the flush cycle is discarded. Data regs may keep stale values. flush has priority
//    over accept and pop.
//  - Reset mid-operation clears everything asynchronously. Held beats are lost.
// CONFIGURATION
//  RESULT_PARITY_EN defined: adds output out_parity (1 bit) = ^out_result, registered
//    with the beat and 0 at reset. Protects the MEM path.
//  RESULT_PARITY_EN undefined: the out_parity port and its logic do not exist.
// TESTING
//  1. Reset then single beat: result=64'hDEAD_BEEF, rd=3, we=1, out_ready=1.
//     -> out_valid next cycle, same fields, occupancy=1 then 0.
//  2. out_ready=0, send 3 back-to-back beats.
//     -> beats 1 and 2 held, in_ready=0 after the 2nd accept, beat 3 waits.
//     Release -> order 1,2,3.
//  3. BEQ zero=1 pc=64'h1000 imm=-16 -> br_taken=1, br_target=64'h0FF0.
//     BNE zero=1 -> br_taken=0.
//     pc=64'hFFFF_FFFF_FFFF_FFF8 imm=16 -> br_target=64'h8.
//  4. rd=0 we=1 result=5 -> out_we=0, out_result=5.
//  5. Occupancy 2 plus flush while in_valid=1.
//     -> next cycle out_valid=0, occupancy=0, in_ready=1, offered beat never appears.
//  6. Assert rst asynchronously mid-stream -> outputs 0 immediately.
//     With RESULT_PARITY_EN: result=64'h7 -> out_parity=1.

Source files
------------

// File: rtl/alu_ex_retire_stage.sv
// EX->MEM retire stage: registers ALU result and writeback control, resolves branches,
// and decouples MEM stalls with a 2-entry main/skid buffer. Optional macro: RESULT_PARITY_EN.
module alu_ex_retire_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_zero,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_we,
    input  logic            in_branch,
    input  logic            in_bne,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_we,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic [1:0]      occupancy
`ifdef RESULT_PARITY_EN
    ,
    output logic            out_parity
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [REGW-1:0] rd;
        logic            we;
        logic            taken;
        logic [XLEN-1:0] target;
`ifdef RESULT_PARITY_EN
        logic            parity;
`endif
    } beat_t;

    beat_t      new_beat;
    beat_t      main_q, main_d;
    beat_t      skid_q, skid_d;
    logic       main_v_q, main_v_d;
    logic       skid_v_q, skid_v_d;
    logic       in_ready_q, in_ready_d;
    logic       br_taken_q, br_taken_d;
    logic [1:0] occ_q, occ_d;
    logic       accept;
    logic       pop;

    // Beat as it will be presented to MEM, fully decoded at capture time.
    always_comb begin
        new_beat        = '0;
        new_beat.result = in_result;
        new_beat.rd     = in_rd;
        new_beat.we     = in_we & (in_rd != '0);
        new_beat.taken  = in_branch & (in_zero ^ in_bne);
        new_beat.target = in_pc + in_imm;
`ifdef RESULT_PARITY_EN
        new_beat.parity = ^in_result;
`endif
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = main_v_q & out_ready;

    // Main/skid next state; skid can only fill while main is held.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (accept) begin
                main_d   = new_beat;
                main_v_d = 1'b1;
            end
        end else if (pop) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = accept;
                if (accept) begin
                    skid_d = new_beat;
                end
            end else begin
                main_v_d = accept;
                if (accept) begin
                    main_d = new_beat;
                end
            end
        end else if (accept) begin
            skid_d   = new_beat;
            skid_v_d = 1'b1;
        end
        occ_d      = 2'(main_v_d) + 2'(skid_v_d);
        in_ready_d = ~skid_v_d;
        br_taken_d = main_v_d & main_d.taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            br_taken_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            br_taken_q <= br_taken_d;
            occ_q      <= occ_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_v_q;
    assign out_result = main_q.result;
    assign out_rd     = main_q.rd;
    assign out_we     = main_q.we;
    assign br_taken   = br_taken_q;
    assign br_target  = main_q.target;
    assign occupancy  = occ_q;
`ifdef RESULT_PARITY_EN
    assign out_parity = main_q.parity;
`endif

endmodule
